pwm_peripheral: RTL and testbench

PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

---
 rtl/pwm_pkg.sv | 36 +++
 rtl/pwm_prescaler.sv | 47 ++++
 rtl/pwm_peripheral.sv | 129 ++++++++++++
 tb/tb_pwm_peripheral.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths, constants and the PWM compare helper used by
// the 16-channel PWM peripheral and its prescaler.
package pwm_pkg;

    // Width of the period counter; one PWM period spans 2**PWM_CNT_W steps.
    localparam int PWM_CNT_W = 8;

    // Duty value that forces the raw level permanently high.
    localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;

    // Last value of the period counter before it wraps back to zero.
    localparam logic [PWM_CNT_W-1:0] CNT_LAST = 8'hFF;

    // Default number of system clocks per PWM count step.
    localparam int CLK_DIV_DEFAULT = 13;

    // Number of output channels.
    localparam int PWM_CHANNELS = 16;

    // Raw PWM level for a given period count and duty value.
    // A full-scale duty holds the level high for the entire period, so
    // 0xFF is special-cased rather than yielding 255/256 high time.
    function automatic logic pwm_level(
        input logic [PWM_CNT_W-1:0] cnt,
        input logic [PWM_CNT_W-1:0] duty
    );
        logic level;
        if (duty == DUTY_FULL) begin
            level = 1'b1;
        end else begin
            level = (cnt < duty);
        end
        return level;
    endfunction

endpackage : pwm_pkg

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: divides the system clock by CLK_DIV and produces a
// single-cycle tick once per division period. Legal CLK_DIV is 1..4096;
// CLK_DIV=1 yields a tick on every clock.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    // A one-bit counter is kept even for CLK_DIV=1 so the vector never
    // collapses to zero width; it simply stays at zero in that case.
    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;

    // Tick is decoded from the registered count, so it is high for exactly
    // the cycle in which the prescaler sits at its terminal value.
    always_comb begin
        tick = (pre_q == PRE_LAST);
    end

    // Next prescaler value: wrap to zero on the terminal count.
    always_comb begin
        pre_d = pre_q;
        if (tick) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + 1'b1;
        end
    end

    // Prescaler state register; reset returns it to zero immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule : pwm_prescaler

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16-channel PWM / static output driver fed from an SPI
// register bank running on the same clock. Each channel is either off,
// statically high, or driven by a shared 8-bit PWM waveform. All channels
// share one prescaler and one period counter, so PWM channels are aligned.
//
// Build option: define PWM_SHADOW_EN to latch the duty value once per
// period (on the wrap from 255 to 0) so mid-period writes only affect the
// following period. Without it the duty input is used directly.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           en_reg_out_7_0,
    input  logic [7:0]           en_reg_out_15_8,
    input  logic [7:0]           en_reg_pwm_7_0,
    input  logic [7:0]           en_reg_pwm_15_8,
    input  logic [7:0]           pwm_duty_cycle,
    output logic [15:0]          out
);

    logic                        tick;
    logic [PWM_CNT_W-1:0]        cnt_q;
    logic [PWM_CNT_W-1:0]        cnt_d;
    logic [PWM_CNT_W-1:0]        duty_eff;
    logic                        period_wrap;
    logic                        raw_level;
    logic [PWM_CHANNELS-1:0]     en_out_all;
    logic [PWM_CHANNELS-1:0]     en_pwm_all;
    logic [PWM_CHANNELS-1:0]     out_q;
    logic [PWM_CHANNELS-1:0]     out_d;

    // Clock divider producing one count step every CLK_DIV clocks.
    pwm_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Gather the byte-wide register fields into channel-indexed vectors.
    always_comb begin
        en_out_all = {en_reg_out_15_8, en_reg_out_7_0};
        en_pwm_all = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    end

    // Period counter advances only on tick; natural 8-bit overflow wraps it.
    always_comb begin
        cnt_d       = cnt_q;
        period_wrap = tick && (cnt_q == CNT_LAST);
        if (tick) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Period counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef PWM_SHADOW_EN
    logic [PWM_CNT_W-1:0] duty_q;
    logic [PWM_CNT_W-1:0] duty_d;

    // Shadow duty reloads only at the period boundary, keeping the
    // current period's high time stable against register writes.
    always_comb begin
        duty_d = duty_q;
        if (period_wrap) begin
            duty_d = pwm_duty_cycle;
        end
    end

    // Shadow duty register; cleared by reset, so the first period after
    // reset is low until the first boundary reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= '0;
        end else begin
            duty_q <= duty_d;
        end
    end

    assign duty_eff = duty_q;
`else
    // Without shadowing the wrap strobe has no consumer.
    logic unused_wrap;
    assign unused_wrap = period_wrap;
    assign duty_eff    = pwm_duty_cycle;
`endif

    // Shared raw waveform compared against the effective duty.
    always_comb begin
        raw_level = pwm_level(cnt_q, duty_eff);
    end

    // Per-channel output select: off, static high, or PWM waveform.
    always_comb begin
        out_d = '0;
        for (int i = 0; i < PWM_CHANNELS; i++) begin
            if (!en_out_all[i]) begin
                out_d[i] = 1'b0;
            end else if (!en_pwm_all[i]) begin
                out_d[i] = 1'b1;
            end else begin
                out_d[i] = raw_level;
            end
        end
    end

    // Output register gives glitch-free drive with one clock of latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule : pwm_peripheral

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: scoreboard bench for pwm_peripheral with CLK_DIV=2.
// Stimulus pushes expected output segments (value held for N samples);
// a monitor samples out 1 ns after every rising edge and checks each
// segment. Expectations for PWM_SHADOW_EN builds are selected by the macro.
module tb_pwm_peripheral;

    localparam int CLK_DIV = 2;

    typedef struct {
        string       name;
        logic [15:0] val;
        int          len;
    } seg_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  en_reg_out_7_0 = '0;
    logic [7:0]  en_reg_out_15_8 = '0;
    logic [7:0]  en_reg_pwm_7_0 = '0;
    logic [7:0]  en_reg_pwm_15_8 = '0;
    logic [7:0]  pwm_duty_cycle = '0;
    logic [15:0] dut_out;

    seg_t        exp_q[$];
    seg_t        cur;
    int          rem = 0;
    int          idx = 0;
    bit          bad = 1'b0;
    int          bad_idx = 0;
    logic [15:0] bad_val = '0;
    int          tests = 0;
    int          fails = 0;

    pwm_peripheral #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .out             (dut_out)
    );

    always #5 clk = ~clk;

    // Monitor: one sample per clock, one comparison per expected segment.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rem == 0 && exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                rem = cur.len;
                idx = 0;
                bad = 1'b0;
            end
            if (rem > 0) begin
                if (dut_out !== cur.val && !bad) begin
                    bad     = 1'b1;
                    bad_idx = idx;
                    bad_val = dut_out;
                end
                idx++;
                rem--;
                if (rem == 0) begin
                    tests++;
                    if (bad) begin
                        fails++;
                        $display("[TB] FAIL %s: sample %0d of %0d out=%h required %h",
                                 cur.name, bad_idx, cur.len, bad_val, cur.val);
                    end else begin
                        $display("[TB] seg %s: out=%h for %0d samples ok",
                                 cur.name, cur.val, cur.len);
                    end
                end
            end
        end
    end

    // Push one expected segment and let it elapse; called on a falling edge.
    task automatic seg(input string name, input logic [15:0] val, input int len);
        seg_t s;
        s.name = name;
        s.val  = val;
        s.len  = len;
        exp_q.push_back(s);
        repeat (len) @(negedge clk);
    endtask

    // Hold reset with the given settings, check out stays low, then release.
    task automatic start_from_reset(input logic [15:0] en_out, input logic [15:0] en_pwm,
                                    input logic [7:0] duty, input int n);
        rst_n           = 1'b0;
        en_reg_out_7_0  = en_out[7:0];
        en_reg_out_15_8 = en_out[15:8];
        en_reg_pwm_7_0  = en_pwm[7:0];
        en_reg_pwm_15_8 = en_pwm[15:8];
        pwm_duty_cycle  = duty;
        seg("in_reset", 16'h0000, n);
        rst_n = 1'b1;
    endtask

    // Directed stimulus.
    initial begin
        @(negedge clk);

        // Reset dominates even with every channel enabled, then idle.
        start_from_reset(16'hFFFF, 16'h0000, 8'h00, 4);
        rst_n = 1'b0;
        en_reg_out_7_0  = '0;
        en_reg_out_15_8 = '0;
        rst_n = 1'b1;
        seg("idle_1024", 16'h0000, 1024);

        // Static enable on all channels appears on the next clock.
        en_reg_out_7_0  = 8'hFF;
        en_reg_out_15_8 = 8'hFF;
        seg("static_on", 16'hFFFF, 20);

        // Duty 0x40 on channel 0: 128 high / 384 low per 512 clocks.
        start_from_reset(16'h0001, 16'h0001, 8'h40, 3);
`ifdef PWM_SHADOW_EN
        seg("d40_shadow_first", 16'h0000, 512);
`endif
        seg("d40_hi_1", 16'h0001, 128);
        seg("d40_lo_1", 16'h0000, 384);
        seg("d40_hi_2", 16'h0001, 128);
        seg("d40_lo_2", 16'h0000, 384);

        // Mixed channels: 15 and 1 static, 0 PWM; duty to 0 mid low phase.
        en_reg_out_15_8 = 8'h80;
        en_reg_out_7_0  = 8'h03;
        seg("mix_hi", 16'h8003, 128);
        seg("mix_lo_a", 16'h8002, 256);
        pwm_duty_cycle = 8'h00;
        seg("mix_lo_b", 16'h8002, 128);
        seg("d00_period", 16'h8002, 511);
        pwm_duty_cycle = 8'hFF;
`ifdef PWM_SHADOW_EN
        seg("d00_last", 16'h8002, 1);
`else
        seg("dff_early", 16'h8003, 1);
`endif
        seg("dff_a", 16'h8003, 200);
        en_reg_out_15_8 = 8'h00;
        en_reg_out_7_0  = 8'h01;
        seg("dff_b_en_change", 16'h0001, 312);

        // Duty 0x40 -> 0xC0 at period counter 100.
        start_from_reset(16'h0001, 16'h0001, 8'h40, 3);
`ifdef PWM_SHADOW_EN
        seg("p1_shadow_zero", 16'h0000, 512);
`else
        seg("p1_hi", 16'h0001, 128);
        seg("p1_lo", 16'h0000, 384);
`endif
        seg("p2_hi", 16'h0001, 128);
        seg("p2_lo_a", 16'h0000, 72);
        pwm_duty_cycle = 8'hC0;
`ifdef PWM_SHADOW_EN
        seg("p2_lo_kept", 16'h0000, 312);
`else
        seg("p2_hi_b", 16'h0001, 184);
        seg("p2_lo_b", 16'h0000, 128);
`endif
        seg("p3_hi", 16'h0001, 384);
        seg("p3_lo", 16'h0000, 128);

        // Reset pulse at period counter 150 with duty 0x80.
        start_from_reset(16'h0001, 16'h0001, 8'h80, 3);
`ifdef PWM_SHADOW_EN
        seg("r1_shadow_zero", 16'h0000, 300);
`else
        seg("r1_hi", 16'h0001, 256);
        seg("r1_lo_to150", 16'h0000, 44);
`endif
        rst_n = 1'b0;
        seg("mid_reset", 16'h0000, 3);
        rst_n = 1'b1;
`ifdef PWM_SHADOW_EN
        seg("r2_shadow_zero", 16'h0000, 512);
`endif
        seg("r2_hi", 16'h0001, 256);
        seg("r2_lo", 16'h0000, 256);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 100 && (exp_q.size() > 0 || rem > 0); i++) begin
            @(negedge clk);
        end
        tests++;
        if (exp_q.size() > 0 || rem > 0) begin
            fails++;
            $display("[TB] FAIL drain: pending=%0d required 0", exp_q.size() + rem);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog against a stalled run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time=%0t required finish before 500000", $time);
        $fatal(1, "watchdog");
    end

endmodule : tb_pwm_peripheral
